// File: rtl/divisor_saturado.sv
// divisor_saturado: signed fixed-point Q(N-FRAC).FRAC divider.
// Restoring division of |num1| << FRAC by |num2|, one quotient bit per
// cycle, followed by sign application and saturation to N bits.
module divisor_saturado #(
   parameter int N    = 24,
   parameter int FRAC = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   output logic [N-1:0] result,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   localparam int W  = N + FRAC;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   localparam logic [N-1:0]  MAXV = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  MINV = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, SAT} state_t;

   state_t          state, state_nx;
   logic [N-1:0]    num1_r, num2_r;
   logic [N-1:0]    mag2_r;
   logic            sign_r;
   logic [W-1:0]    d;         // dividend shifts out MSB first, quotient shifts in
   logic [N-1:0]    rem;
   logic [CW-1:0]   cnt;

   logic [N-1:0]    abs1, abs2;
   logic [N:0]      trial;
   logic            ge;
   logic [N-1:0]    diff;
   logic [N-1:0]    rem_nx;
   logic            q_hi;
   logic            pos_ovf, neg_ovf;
   logic [N-1:0]    sat_val;

   // Magnitudes as N-bit unsigned: negating the most negative value
   // yields 2^(N-1), which is exactly representable unsigned.
   assign abs1 = num1[N-1] ? -num1 : num1;
   assign abs2 = num2[N-1] ? -num2 : num2;

   assign busy = (state != IDLE);

   // One restoring-division step; remainder stays below the divisor,
   // so the N-bit difference is exact whenever the trial is accepted.
   always_comb begin
      trial  = {rem, d[W-1]};
      ge     = (trial >= {1'b0, mag2_r});
      diff   = trial[N-1:0] - mag2_r;
      rem_nx = ge ? diff : trial[N-1:0];
   end

   // Saturate the unsigned quotient and apply the captured sign.
   always_comb begin
      q_hi    = |d[W-1:N];
      pos_ovf = q_hi | d[N-1];
      neg_ovf = q_hi | (d[N-1] & (|d[N-2:0]));
      sat_val = '0;
      if (num2_r == '0) begin
         if (num1_r == '0)
            sat_val = '0;
         else if (num1_r[N-1])
            sat_val = MINV;
         else
            sat_val = MAXV;
      end else if (!sign_r && pos_ovf) begin
         sat_val = MAXV;
      end else if (sign_r && neg_ovf) begin
         sat_val = MINV;
      end else begin
         sat_val = sign_r ? -d[N-1:0] : d[N-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = (num2 == '0) ? SAT : CALC;
         CALC: if (cnt == LAST) state_nx = SAT;
         SAT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         num1_r   <= '0;
         num2_r   <= '0;
         mag2_r   <= '0;
         sign_r   <= 1'b0;
         d        <= '0;
         rem      <= '0;
         cnt      <= '0;
         result   <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num1_r <= num1;
                  num2_r <= num2;
                  mag2_r <= abs2;
                  sign_r <= num1[N-1] ^ num2[N-1];
                  d      <= {abs1, {FRAC{1'b0}}};
                  rem    <= '0;
                  cnt    <= '0;
               end
            end
            CALC: begin
               d   <= {d[W-2:0], ge};
               rem <= rem_nx;
               cnt <= cnt + CW'(1);
            end
            SAT: begin
               result   <= sat_val;
               div_zero <= (num2_r == '0);
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_saturado.sv
// Self-checking bench for divisor_saturado (N=24, FRAC=16).
module tb_divisor_saturado;

   localparam int N    = 24;
   localparam int FRAC = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic [N-1:0]  num1, num2;
   logic [N-1:0]  result;
   logic          busy, done, div_zero;

   int            checks   = 0;
   int            failures = 0;

   logic [N-1:0]  exp_res;
   logic          exp_dz;
   int            exp_lat;
   logic [N-1:0]  prev_res;

   divisor_saturado #(.N(N), .FRAC(FRAC)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .num1     (num1),
      .num2     (num2),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact signed arithmetic, truncating division, then clamp.
   function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa, sb, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         if (sa == 0)     return '0;
         else if (sa < 0) return 24'h800000;
         else             return 24'h7FFFFF;
      end
      q = (sa * 65536) / sb;
      if (q > 64'sd8388607)  return 24'h7FFFFF;
      if (q < -64'sd8388608) return 24'h800000;
      return q[N-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive a request at the current falling edge.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
      start   = 1'b1;
      num1    = a;
      num2    = b;
      exp_res = model(a, b);
      exp_dz  = (b == '0);
      exp_lat = (b == '0) ? 2 : N + FRAC + 2;
   endtask

   // Wait for done (bounded), scrambling inputs and pulsing an ignored start.
   task automatic finish_op(input string tag);
      int cnt;
      bit got;
      cnt = 0;
      got = 0;
      while (!got && cnt < 100) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (cnt == 1) begin
            start = 1'b0;
            num1  = 24'($urandom);
            num2  = 24'($urandom);
            chk({tag, " held"}, 32'(result), 32'(prev_res));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " donelow"}, 32'(done), 32'd0);
         end
         if (cnt == 10 && exp_lat > 10) begin
            start = 1'b1;
            num1  = 24'($urandom);
            num2  = 24'($urandom);
         end
         if (cnt == 11) start = 1'b0;
         if (done === 1'b1) got = 1;
      end
      chk({tag, " latency"}, 32'(cnt), 32'(exp_lat));
      chk({tag, " result"}, 32'(result), 32'(exp_res));
      chk({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
      chk({tag, " idle"}, 32'(busy), 32'd0);
      prev_res = exp_res;
   endtask

   initial begin
      bit saw_done;
      logic [N-1:0] a, b;
      reset    = 1'b1;
      start    = 1'b0;
      num1     = '0;
      num2     = '0;
      prev_res = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst result", 32'(result), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst div_zero", 32'(div_zero), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors; each launch follows the previous done directly.
      launch(24'h060000, 24'h020000); finish_op("6/2");
      launch(24'h010000, 24'h030000); finish_op("1/3");
      launch(24'hFF0000, 24'h030000); finish_op("-1/3");
      launch(24'h640000, 24'h000001); finish_op("sat pos");
      launch(24'h9C0000, 24'h000001); finish_op("sat neg");
      launch(24'h010000, 24'h000000); finish_op("dz pos");
      launch(24'h000000, 24'h000000); finish_op("dz zero");
      launch(24'hF00000, 24'h000000); finish_op("dz neg");
      launch(24'h800000, 24'hFF0000); finish_op("min/-1");
      launch(24'hFFC000, 24'h010000); finish_op("b2b");
      launch(24'h800000, 24'h010000); finish_op("min/1");
      launch(24'h000000, 24'hFD0000); finish_op("zero/neg");

      // Reset mid-calculation aborts with no done pulse.
      launch(24'h123456, 24'h000321);
      saw_done = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 10) start = 1'b1;
         if (i == 11) start = 1'b0;
         if (done === 1'b1) saw_done = 1;
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort no done", 32'(saw_done), 32'd0);
      chk("abort result", 32'(result), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort div_zero", 32'(div_zero), 32'd0);
      reset    = 1'b0;
      prev_res = '0;
      launch(24'h050000, 24'hFE0000); finish_op("post reset");

      // Randomized operations with occasional idle gaps.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               @(negedge clk);
            end
         end
         a = 24'($urandom);
         if ($urandom_range(0, 5) == 0) a = '0;
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = 24'($urandom_range(1, 255));
            2: b = 24'($urandom);
            default: b = 24'($urandom) >> $urandom_range(0, 20);
         endcase
         launch(a, b);
         finish_op("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
